// File: rtl/tmu2_pkg.sv
// Shared types and constants for the TMU2 horizontal interpolator controller.
// Holds the FSM encoding, datapath widths and the per-channel delta helper.
package tmu2_pkg;

    localparam int XW        = 12;
    localparam int CW        = 18;
    localparam int QW        = 17;
    localparam int DIV_ITERS = 17;

    typedef enum logic [2:0] {
        IDLE,
        DIV_U,
        DIV_V,
        LOAD,
        EMIT
    } state_t;

    typedef struct packed {
        logic          pos;
        logic [QW-1:0] mag;
    } delta_t;

    // Direction and saturated magnitude of c1-c0, done in CW+1 bits.
    function automatic delta_t chan_delta(
        input logic signed [CW-1:0] c0,
        input logic signed [CW-1:0] c1
    );
        logic signed [CW:0] d;
        logic        [CW:0] a;
        delta_t             res;
        d       = {c1[CW-1], c1} - {c0[CW-1], c0};
        a       = d[CW] ? $unsigned(-d) : $unsigned(d);
        res.pos = ~d[CW];
        res.mag = (|a[CW:QW]) ? {QW{1'b1}} : a[QW-1:0];
        return res;
    endfunction

endpackage

// File: rtl/tmu2_hinterp_ctl_if.sv
// Span-in / point-out bundle for tmu2_hinterp_ctl, plus interpolator control.
// master: span source, point sink and interpolator pair; slave: the controller.
interface tmu2_hinterp_ctl_if;
    import tmu2_pkg::*;

    logic                 pipe_stb_i;
    logic                 pipe_ack_o;
    logic signed [XW-1:0] x0;
    logic signed [XW-1:0] x1;
    logic signed [XW-1:0] y;
    logic signed [CW-1:0] u0;
    logic signed [CW-1:0] u1;
    logic signed [CW-1:0] v0;
    logic signed [CW-1:0] v1;
    logic                 busy;
    logic                 load;
    logic                 next_point;
    logic signed [CW-1:0] init_u;
    logic signed [CW-1:0] init_v;
    logic                 positive_u;
    logic                 positive_v;
    logic        [QW-1:0] q_u;
    logic        [QW-1:0] r_u;
    logic        [QW-1:0] q_v;
    logic        [QW-1:0] r_v;
    logic        [QW-1:0] divisor;
    logic signed [CW-1:0] u_i;
    logic signed [CW-1:0] v_i;
    logic                 pipe_stb_o;
    logic                 pipe_ack_i;
    logic signed [XW-1:0] x_o;
    logic signed [XW-1:0] y_o;
    logic signed [CW-1:0] u_o;
    logic signed [CW-1:0] v_o;

    modport master (
        output pipe_stb_i, x0, x1, y, u0, u1, v0, v1,
        output u_i, v_i, pipe_ack_i,
        input  pipe_ack_o, busy, load, next_point,
        input  init_u, init_v, positive_u, positive_v,
        input  q_u, r_u, q_v, r_v, divisor,
        input  pipe_stb_o, x_o, y_o, u_o, v_o
    );

    modport slave (
        input  pipe_stb_i, x0, x1, y, u0, u1, v0, v1,
        input  u_i, v_i, pipe_ack_i,
        output pipe_ack_o, busy, load, next_point,
        output init_u, init_v, positive_u, positive_v,
        output q_u, r_u, q_v, r_v, divisor,
        output pipe_stb_o, x_o, y_o, u_o, v_o
    );

endinterface

// File: rtl/tmu2_hinterp_ctl_serdiv.sv
// tmu2_serdiv17: restoring serial divider, MSB first, one quotient bit per cycle.
// Ports: start/dividend/divisor in; done pulse with q/r valid in the same cycle.
module tmu2_serdiv17
    import tmu2_pkg::*;
(
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic [QW-1:0] dividend,
    input  logic [XW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] q,
    output logic [QW-1:0] r
);

    logic [QW-1:0] quo;
    logic [XW-1:0] rem;
    logic [XW-1:0] dsr;
    logic [4:0]    cnt;
    logic [XW:0]   trial;
    logic          fits;
    logic [XW-1:0] rem_nx;
    logic [QW-1:0] quo_nx;

    // rem < divisor always holds, so the shifted trial fits in XW+1 bits.
    always_comb begin
        trial  = {rem, quo[QW-1]};
        fits   = trial >= {1'b0, dsr};
        rem_nx = fits ? XW'(trial - {1'b0, dsr}) : trial[XW-1:0];
        quo_nx = {quo[QW-2:0], fits};
    end

    // The last iteration is presented combinationally with done.
    assign done = (cnt == 5'd1);
    assign q    = quo_nx;
    assign r    = {{(QW-XW){1'b0}}, rem_nx};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (start) begin
            quo <= dividend;
            rem <= '0;
            dsr <= divisor;
            cnt <= 5'(DIV_ITERS);
        end else if (cnt != 5'd0) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/tmu2_hinterp_ctl.sv
// Span sequencer for a u/v pair of tmu2_geninterp18 interpolators.
// Ports: sys_clk, sys_rst_n, and bus (slave side of tmu2_hinterp_ctl_if).
module tmu2_hinterp_ctl
    import tmu2_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    tmu2_hinterp_ctl_if.slave  bus
);

    state_t        state;
    state_t        state_nx;
    logic [XW-1:0] k;
    logic [XW-1:0] n_r;
    logic [XW-1:0] x0_r;
    logic [XW-1:0] y_r;
    logic [QW-1:0] m_v_r;
    logic [XW-1:0] n_in;
    logic          accept;
    logic          last;
    delta_t        du;
    delta_t        dv;
    logic          div_start;
    logic          div_done;
    logic [QW-1:0] div_q;
    logic [QW-1:0] div_r;
    logic [QW-1:0] div_dvd;
    logic [XW-1:0] div_dsr;

    assign n_in   = bus.x1 - bus.x0;
    assign du     = chan_delta(bus.u0, bus.u1);
    assign dv     = chan_delta(bus.v0, bus.v1);
    assign accept = (state == IDLE) && bus.pipe_stb_i;
    assign last   = (k == n_r);

    // u is divided straight from the span inputs at capture time;
    // v reuses the divider from its latched magnitude.
    assign div_start = (accept && (n_in != '0))
                     || ((state == DIV_U) && div_done);
    assign div_dvd   = (state == IDLE) ? du.mag : m_v_r;
    assign div_dsr   = (state == IDLE) ? n_in : n_r;

    tmu2_serdiv17 u_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (div_start),
        .dividend  (div_dvd),
        .divisor   (div_dsr),
        .done      (div_done),
        .q         (div_q),
        .r         (div_r)
    );

    always_comb begin
        state_nx       = state;
        bus.pipe_ack_o = 1'b0;
        bus.busy       = 1'b1;
        bus.load       = 1'b0;
        bus.next_point = 1'b0;
        bus.pipe_stb_o = 1'b0;
        unique case (state)
            IDLE: begin
                bus.pipe_ack_o = 1'b1;
                bus.busy       = 1'b0;
                if (bus.pipe_stb_i)
                    state_nx = (n_in != '0) ? DIV_U : LOAD;
            end
            DIV_U: if (div_done) state_nx = DIV_V;
            DIV_V: if (div_done) state_nx = LOAD;
            LOAD: begin
                bus.load = 1'b1;
                state_nx = EMIT;
            end
            EMIT: begin
                bus.pipe_stb_o = 1'b1;
                if (bus.pipe_ack_i) begin
                    if (last) state_nx = IDLE;
                    else bus.next_point = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            k              <= '0;
            n_r            <= '0;
            x0_r           <= '0;
            y_r            <= '0;
            m_v_r          <= '0;
            bus.init_u     <= '0;
            bus.init_v     <= '0;
            bus.positive_u <= 1'b0;
            bus.positive_v <= 1'b0;
            bus.q_u        <= '0;
            bus.r_u        <= '0;
            bus.q_v        <= '0;
            bus.r_v        <= '0;
            bus.divisor    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                x0_r           <= bus.x0;
                y_r            <= bus.y;
                n_r            <= n_in;
                m_v_r          <= dv.mag;
                bus.init_u     <= bus.u0;
                bus.init_v     <= bus.v0;
                bus.positive_u <= du.pos;
                bus.positive_v <= dv.pos;
                bus.q_u        <= '0;
                bus.r_u        <= '0;
                bus.q_v        <= '0;
                bus.r_v        <= '0;
                bus.divisor    <= (n_in == '0) ? QW'(1) : QW'(n_in);
            end
            if ((state == DIV_U) && div_done) begin
                bus.q_u <= div_q;
                bus.r_u <= div_r;
            end
            if ((state == DIV_V) && div_done) begin
                bus.q_v <= div_q;
                bus.r_v <= div_r;
            end
            if (state == LOAD)
                k <= '0;
            else if (bus.next_point)
                k <= k + XW'(1);
        end
    end

    assign bus.x_o = x0_r + k;
    assign bus.y_o = y_r;
    assign bus.u_o = bus.u_i;
    assign bus.v_o = bus.v_i;

endmodule

// File: tb/tb_tmu2_hinterp_ctl.sv
// Directed bench for tmu2_hinterp_ctl with a behavioural u/v interpolator pair.
// Span vectors are table driven; reset-mid-division is a hand sequence.
module tb_tmu2_hinterp_ctl;

    logic sys_clk;
    logic sys_rst_n;
    int   passed;
    int   total;
    int   iu, eu, iv, ev;

    tmu2_hinterp_ctl_if bus ();

    tmu2_hinterp_ctl dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int x0, x1, y, u0, u1, v0, v1;
        int q_u, r_u, pos_u, dv, first;
        int stall_at, stall_len;
        int ue[5];
        int ve[5];
    } vec_t;

    vec_t tv[6];

    // External interpolator: error-accumulating step with rounding.
    function automatic void istep(
        input int o, input int e, input int q, input int r,
        input int d, input bit pos, output int no, output int ne
    );
        int s;
        s = e + r;
        if (2 * s > d) begin
            no = pos ? o + q + 1 : o - q - 1;
            ne = s - d;
        end else begin
            no = pos ? o + q : o - q;
            ne = s;
        end
    endfunction

    initial begin
        iu = 0; eu = 0; iv = 0; ev = 0;
    end

    always @(posedge sys_clk) begin
        int a, b, c, d;
        if (bus.load) begin
            iu <= bus.init_u;
            iv <= bus.init_v;
            eu <= 0;
            ev <= 0;
        end else if (bus.next_point) begin
            istep(iu, eu, int'(bus.q_u), int'(bus.r_u),
                  int'(bus.divisor), bus.positive_u, a, b);
            istep(iv, ev, int'(bus.q_v), int'(bus.r_v),
                  int'(bus.divisor), bus.positive_v, c, d);
            iu <= a;
            eu <= b;
            iv <= c;
            ev <= d;
        end
    end

    assign bus.u_i = iu[17:0];
    assign bus.v_i = iv[17:0];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic run_span(input vec_t t);
        int c, lc, n;
        n = t.x1 - t.x0;
        chk("ack_idle", int'(bus.pipe_ack_o), 1);
        bus.x0 = 12'(t.x0);
        bus.x1 = 12'(t.x1);
        bus.y  = 12'(t.y);
        bus.u0 = 18'(t.u0);
        bus.u1 = 18'(t.u1);
        bus.v0 = 18'(t.v0);
        bus.v1 = 18'(t.v1);
        bus.pipe_stb_i = 1'b1;
        @(negedge sys_clk);
        bus.pipe_stb_i = 1'b0;
        c  = 1;
        lc = 0;
        while (!bus.pipe_stb_o && c < 100) begin
            if (bus.load) lc = c;
            @(negedge sys_clk);
            c++;
        end
        chk("first_stb", c, t.first);
        chk("load_cyc", lc, t.first - 1);
        chk("q_u", int'(bus.q_u), t.q_u);
        chk("r_u", int'(bus.r_u), t.r_u);
        chk("pos_u", int'(bus.positive_u), t.pos_u);
        chk("divisor", int'(bus.divisor), t.dv);
        chk("init_u", int'(bus.init_u), t.u0);
        chk("init_v", int'(bus.init_v), t.v0);
        for (int k = 0; k <= n; k++) begin
            if (k == t.stall_at) begin
                for (int s = 0; s < t.stall_len; s++) begin
                    bus.pipe_ack_i = 1'b0;
                    #1;
                    chk("hold_stb", int'(bus.pipe_stb_o), 1);
                    chk("hold_u", int'(bus.u_o), t.ue[k]);
                    chk("hold_np", int'(bus.next_point), 0);
                    @(negedge sys_clk);
                end
            end
            bus.pipe_ack_i = 1'b1;
            #1;
            chk("pt_stb", int'(bus.pipe_stb_o), 1);
            chk("pt_x", int'(bus.x_o), t.x0 + k);
            chk("pt_y", int'(bus.y_o), t.y);
            chk("pt_u", int'(bus.u_o), t.ue[k]);
            chk("pt_v", int'(bus.v_o), t.ve[k]);
            chk("pt_np", int'(bus.next_point), (k < n) ? 1 : 0);
            chk("pt_load", int'(bus.load), 0);
            @(negedge sys_clk);
        end
        bus.pipe_ack_i = 1'b0;
        chk("end_ack", int'(bus.pipe_ack_o), 1);
        chk("end_stb", int'(bus.pipe_stb_o), 0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        tv[0] = '{10, 14, 5, 0, 100, 50, 50, 25, 0, 1, 4, 36, -1, 0,
                  '{0, 25, 50, 75, 100}, '{50, 50, 50, 50, 50}};
        tv[1] = '{10, 14, 5, 100, 0, 50, 50, 25, 0, 0, 4, 36, -1, 0,
                  '{100, 75, 50, 25, 0}, '{50, 50, 50, 50, 50}};
        tv[2] = '{0, 3, 2, 0, 10, 20, -20, 3, 1, 1, 3, 36, -1, 0,
                  '{0, 3, 7, 10, 0}, '{20, 7, -7, -20, 0}};
        tv[3] = '{7, 7, 9, 5, 5, -9, -9, 0, 0, 1, 1, 2, -1, 0,
                  '{5, 0, 0, 0, 0}, '{-9, 0, 0, 0, 0}};
        tv[4] = '{10, 14, 5, 0, 100, 50, 50, 25, 0, 1, 4, 36, 2, 3,
                  '{0, 25, 50, 75, 100}, '{50, 50, 50, 50, 50}};
        tv[5] = '{-5, -4, -3, -131072, 131071, 0, 0,
                  131071, 0, 1, 1, 36, -1, 0,
                  '{-131072, -1, 0, 0, 0}, '{0, 0, 0, 0, 0}};

        sys_rst_n      = 1'b0;
        bus.pipe_stb_i = 1'b0;
        bus.pipe_ack_i = 1'b0;
        bus.x0 = '0; bus.x1 = '0; bus.y = '0;
        bus.u0 = '0; bus.u1 = '0; bus.v0 = '0; bus.v1 = '0;
        repeat (2) @(negedge sys_clk);
        chk("rst_ack", int'(bus.pipe_ack_o), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_stb", int'(bus.pipe_stb_o), 0);
        chk("rst_load", int'(bus.load), 0);
        chk("rst_div", int'(bus.divisor), 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        for (int i = 0; i < 6; i++) run_span(tv[i]);

        // Reset while the v division is in progress.
        bus.x0 = 12'sd10; bus.x1 = 12'sd14; bus.y = 12'sd5;
        bus.u0 = 18'sd0;  bus.u1 = 18'sd100;
        bus.v0 = 18'sd50; bus.v1 = 18'sd50;
        bus.pipe_stb_i = 1'b1;
        @(negedge sys_clk);
        bus.pipe_stb_i = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("mid_busy", int'(bus.busy), 1);
        chk("mid_ack", int'(bus.pipe_ack_o), 0);
        sys_rst_n = 1'b0;
        #1;
        chk("arst_ack", int'(bus.pipe_ack_o), 1);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_stb", int'(bus.pipe_stb_o), 0);
        chk("arst_q_u", int'(bus.q_u), 0);
        chk("arst_div", int'(bus.divisor), 0);
        chk("arst_init", int'(bus.init_v), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("post_stb", int'(bus.pipe_stb_o), 0);
        run_span(tv[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
